// File: rtl/fft_dif_inv_butterfly_if.sv
// rtl/fft_dif_inv_butterfly_if.sv - handshake and data bundle for the inverse DIF butterfly
interface fft_dif_inv_butterfly_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] x_N;
  logic [DATA_WIDTH-1:0] x_M;
  logic [DATA_WIDTH-1:0] w_N;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] y_N;
  logic [DATA_WIDTH-1:0] y_M;
  logic                  ovf;

  modport slave (
    input  in_valid, x_N, x_M, w_N, out_ready,
    output in_ready, out_valid, y_N, y_M, ovf
  );

  modport master (
    output in_valid, x_N, x_M, w_N, out_ready,
    input  in_ready, out_valid, y_N, y_M, ovf
  );
endinterface

// File: rtl/fft_dif_inv_butterfly.sv
// rtl/fft_dif_inv_butterfly.sv - 3-stage inverse radix-2 DIF butterfly; IFFT_SCALE_EN enables per-stage 1/2 scaling
module fft_dif_inv_butterfly #(
  parameter int DATA_WIDTH = 32,
  parameter int TW_FRAC    = DATA_WIDTH/2 - 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  fft_dif_inv_butterfly_if.slave  bus
);

  localparam int H  = DATA_WIDTH/2;
  // Working width: full-precision product (2H+2) plus one guard bit for the rounding add.
  localparam int RW = 2*H + 3;

`ifdef IFFT_SCALE_EN
  localparam int SH_N = 1;
  localparam int SH_M = TW_FRAC + 1;
  localparam bit RND  = 1'b1;
`else
  localparam int SH_N = 0;
  localparam int SH_M = TW_FRAC;
  localparam bit RND  = 1'b0;
`endif

  // Returns {clipped, value}: optional half-LSB add, arithmetic shift, clamp to H bits.
  function automatic logic [H:0] round_sat(input logic signed [RW-1:0] v,
                                           input int sh, input bit rnd);
    logic signed [RW-1:0] half;
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] maxv;
    logic signed [RW-1:0] minv;
    maxv         = '0;
    maxv[H-2:0]  = '1;
    minv         = '1;
    minv[H-2:0]  = '0;
    half = (rnd && (sh > 0)) ? (RW'(1) << (sh - 1)) : '0;
    r    = (v + half) >>> sh;
    if (r > maxv) begin
      round_sat = {1'b1, maxv[H-1:0]};
    end else if (r < minv) begin
      round_sat = {1'b1, minv[H-1:0]};
    end else begin
      round_sat = {1'b0, r[H-1:0]};
    end
  endfunction

  logic en;
  logic v1, v2, v3;

  logic signed [H-1:0] n1_r, n1_i, m1_r, m1_i, w1_r, w1_i;
  logic signed [H:0]   s2_r, s2_i, d2_r, d2_i;
  logic signed [H-1:0] w2_r, w2_i;

  logic [DATA_WIDTH-1:0] y_n_q, y_m_q;
  logic                  ovf_q;

  logic signed [RW-1:0] p_r, p_i;
  logic [H:0]           rn_r, rn_i, rm_r, rm_i;
  logic                 ovf_c;

  // A stalled stage 3 freezes the whole pipe; only out_ready reaches in_ready combinationally.
  assign en            = !v3 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.y_N       = y_n_q;
  assign bus.y_M       = y_m_q;
  assign bus.ovf       = ovf_q;

  // Valid bits advance together whenever the pipe is enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (en) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Stage 1: capture the operands split into real/imag halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n1_r <= '0; n1_i <= '0;
      m1_r <= '0; m1_i <= '0;
      w1_r <= '0; w1_i <= '0;
    end else if (en) begin
      n1_r <= bus.x_N[DATA_WIDTH-1:H]; n1_i <= bus.x_N[H-1:0];
      m1_r <= bus.x_M[DATA_WIDTH-1:H]; m1_i <= bus.x_M[H-1:0];
      w1_r <= bus.w_N[DATA_WIDTH-1:H]; w1_i <= bus.w_N[H-1:0];
    end
  end

  // Stage 2: one-bit-grown sum and difference, twiddle carried along.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_r <= '0; s2_i <= '0;
      d2_r <= '0; d2_i <= '0;
      w2_r <= '0; w2_i <= '0;
    end else if (en) begin
      s2_r <= (H+1)'(n1_r) + (H+1)'(m1_r);
      s2_i <= (H+1)'(n1_i) + (H+1)'(m1_i);
      d2_r <= (H+1)'(n1_r) - (H+1)'(m1_r);
      d2_i <= (H+1)'(n1_i) - (H+1)'(m1_i);
      w2_r <= w1_r;
      w2_i <= w1_i;
    end
  end

  // Difference times conj(w) at full precision, then scale/round/clamp both legs.
  always_comb begin
    p_r   = RW'(d2_r) * RW'(w2_r) + RW'(d2_i) * RW'(w2_i);
    p_i   = RW'(d2_i) * RW'(w2_r) - RW'(d2_r) * RW'(w2_i);
    rn_r  = round_sat(RW'(s2_r), SH_N, RND);
    rn_i  = round_sat(RW'(s2_i), SH_N, RND);
    rm_r  = round_sat(p_r, SH_M, RND);
    rm_i  = round_sat(p_i, SH_M, RND);
    ovf_c = rn_r[H] | rn_i[H] | rm_r[H] | rm_i[H];
  end

  // Stage 3: registered outputs, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_n_q <= '0;
      y_m_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      y_n_q <= {rn_r[H-1:0], rn_i[H-1:0]};
      y_m_q <= {rm_r[H-1:0], rm_i[H-1:0]};
      ovf_q <= v2 && ovf_c;
    end
  end

endmodule
